// File: rtl/alu_issue_pkg.sv
// Shared constants for the alu_issue slice: datapath width, default register count
// and the 3-bit ALU opcodes understood by the downstream ALU.
package alu_issue_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int NREGS_DEFAULT = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_opcode_e;

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: one write port, three asynchronous read ports.
// Register 0 is hard-wired to zero and ignores writes.
module alu_issue_regfile #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [RW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [RW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [RW-1:0]    raddr_c,
    output logic [WIDTH-1:0] rdata_c
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-write value on a writeback edge.
    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
    assign rdata_c = (raddr_c == '0) ? '0 : mem[raddr_c];

endmodule

// File: rtl/alu_issue.sv
// Single-issue ALU front end: operand read/select, RAW hazard check and writeback.
// Define ALU_ISSUE_FWD_EN to forward alu_out to a dependent issue instead of stalling.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           instr_op,
    input  logic [RW-1:0]        instr_rd,
    input  logic [RW-1:0]        instr_rs1,
    input  logic [RW-1:0]        instr_rs2,
    input  logic                 instr_imm_en,
    input  logic [WORD_SIZE-1:0] instr_imm,
    output logic [2:0]           alu_op,
    output logic [WORD_SIZE-1:0] alu_in1,
    output logic [WORD_SIZE-1:0] alu_in2,
    output logic                 alu_enable,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic                 busy,
    input  logic [RW-1:0]        dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data
);

    logic                 s1_valid, s2_valid;
    logic [RW-1:0]        s1_rd, s2_rd;
    logic [WORD_SIZE-1:0] rs1_data, rs2_data, op1, op2;
    logic                 use_rs1, use_rs2;
    logic                 s1_hit_rs1, s1_hit_rs2, s2_hit_rs1, s2_hit_rs2;
    logic                 hazard, accept;

    alu_issue_regfile #(
        .NREGS(NREGS),
        .WIDTH(WORD_SIZE)
    ) regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (s2_valid),
        .waddr   (s2_rd),
        .wdata   (alu_out),
        .raddr_a (instr_rs1),
        .rdata_a (rs1_data),
        .raddr_b (instr_rs2),
        .rdata_b (rs2_data),
        .raddr_c (dbg_addr),
        .rdata_c (dbg_data)
    );

    // r0 never creates a dependency, and an immediate hides rs2 entirely.
    assign use_rs1    = (instr_rs1 != '0);
    assign use_rs2    = !instr_imm_en && (instr_rs2 != '0);
    assign s1_hit_rs1 = use_rs1 && s1_valid && (s1_rd == instr_rs1);
    assign s1_hit_rs2 = use_rs2 && s1_valid && (s1_rd == instr_rs2);
    assign s2_hit_rs1 = use_rs1 && s2_valid && (s2_rd == instr_rs1);
    assign s2_hit_rs2 = use_rs2 && s2_valid && (s2_rd == instr_rs2);

`ifdef ALU_ISSUE_FWD_EN
    assign hazard = s1_hit_rs1 || s1_hit_rs2;
`else
    assign hazard = s1_hit_rs1 || s1_hit_rs2 || s2_hit_rs1 || s2_hit_rs2;
`endif

    assign instr_ready = rst_n && !hazard;
    assign accept      = instr_valid && instr_ready;
    assign busy        = s1_valid || s2_valid;
    assign alu_enable  = s1_valid;

    always_comb begin
        op1 = rs1_data;
        op2 = instr_imm_en ? instr_imm : rs2_data;
`ifdef ALU_ISSUE_FWD_EN
        // The S2 result is on alu_out this cycle but not yet in the register file.
        if (s2_hit_rs1) op1 = alu_out;
        if (s2_hit_rs2) op2 = alu_out;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_rd    <= '0;
            s2_rd    <= '0;
            alu_op   <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s2_rd    <= s1_rd;
            if (accept) begin
                s1_rd   <= instr_rd;
                alu_op  <= instr_op;
                alu_in1 <= op1;
                alu_in2 <= op2;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus a random stream checked
// against an in-order architectural model; honours ALU_ISSUE_FWD_EN like the design.
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int NREGS = 8;
    localparam int RW    = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 instr_valid = 1'b0;
    logic                 instr_ready;
    logic [2:0]           instr_op = '0;
    logic [RW-1:0]        instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
    logic                 instr_imm_en = 1'b0;
    logic [WORD_SIZE-1:0] instr_imm = '0;
    logic [2:0]           alu_op;
    logic [WORD_SIZE-1:0] alu_in1, alu_in2;
    logic                 alu_enable;
    logic [WORD_SIZE-1:0] alu_out = '0;
    logic                 busy;
    logic [RW-1:0]        dbg_addr = '0;
    logic [WORD_SIZE-1:0] dbg_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Architectural model: registers updated in program order at accept time.
    logic [WORD_SIZE-1:0] mreg [NREGS];
    int acc_edge[$];
    int acc_rd[$];

    alu_issue #(.NREGS(NREGS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .alu_op       (alu_op),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_enable   (alu_enable),
        .alu_out      (alu_out),
        .busy         (busy),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WORD_SIZE-1:0] alu_fn(input logic [2:0] op,
                                                    input logic [WORD_SIZE-1:0] a,
                                                    input logic [WORD_SIZE-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_MUL: return a * b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SHL: return a << b[3:0];
            default: return a >> b[3:0];
        endcase
    endfunction

    // External ALU: result registered one clock after alu_enable.
    always @(posedge clk) begin
        if (alu_enable) alu_out <= alu_fn(alu_op, alu_in1, alu_in2);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) mreg[i] = '0;
    endtask

    // Presents one instruction from the next negedge and holds it until accepted.
    task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                         input bit imm_en, input logic [WORD_SIZE-1:0] imm,
                         output int start, output int bubbles);
        logic [WORD_SIZE-1:0] a, b;
        bit ok;
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_op     = op;
        instr_rd     = RW'(rd);
        instr_rs1    = RW'(rs1);
        instr_rs2    = RW'(rs2);
        instr_imm_en = imm_en;
        instr_imm    = imm;
        #1;
        start   = cyc;
        bubbles = 0;
        while (!instr_ready && bubbles < 8) begin
            @(negedge clk);
            #1;
            bubbles++;
        end
        ok = instr_ready;
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL accept_timeout: ready=%0b after %0d cycles, required 1", instr_ready, bubbles);
            instr_valid = 1'b0;
        end else begin
            a = (rs1 == 0) ? '0 : mreg[rs1];
            b = imm_en ? imm : ((rs2 == 0) ? '0 : mreg[rs2]);
            if (rd != 0) mreg[rd] = alu_fn(op, a, b);
        end
        @(posedge clk);
        #1;
        if (ok) begin
            acc_edge.push_back(cyc);
            acc_rd.push_back(rd);
        end
    endtask

    task automatic drain(input int n);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
        #1;
    endtask

    // Stall rule: a producer blocks its consumer while in S1, and while in S2 unless forwarding.
    function automatic int predict_bubbles(input int start, input int n, input int rs1,
                                           input int rs2, input bit imm_en);
        int c;
        bit blocked;
        c = start;
        do begin
            blocked = 1'b0;
            for (int i = 0; i < n; i++) begin
                if ((rs1 != 0 && acc_rd[i] == rs1) || (!imm_en && rs2 != 0 && acc_rd[i] == rs2)) begin
                    if (c == acc_edge[i]) blocked = 1'b1;
`ifndef ALU_ISSUE_FWD_EN
                    if (c == acc_edge[i] + 1) blocked = 1'b1;
`endif
                end
            end
            if (blocked) c++;
        end while (blocked);
        return c - start;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b1;
        instr_rs1 = 3'd1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (instr_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_ready: got %b, required 0", instr_ready);
            end
            checks++;
            if (alu_enable !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_alu_enable: got %b, required 0", alu_enable);
            end
        end
        checks++;
        if (busy !== 1'b0 || alu_op !== 3'd0 || alu_in1 !== '0 || alu_in2 !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: busy=%b op=%0d in1=%0d in2=%0d, required all 0",
                     busy, alu_op, alu_in1, alu_in2);
        end
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = RW'(i);
            #1;
            checks++;
            if (dbg_data !== '0) begin
                failures++;
                $display("[TB] FAIL reset_reg r%0d: got %0d, required 0", i, dbg_data);
            end
        end
        clear_model();
        instr_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_independent();
        int s, b1, b2;
        issue(ALU_ADD, 1, 0, 0, 1'b1, 16'd5, s, b1);
        issue(ALU_ADD, 2, 0, 0, 1'b1, 16'd7, s, b2);
        checks++;
        if (b1 != 0 || b2 != 0) begin
            failures++;
            $display("[TB] FAIL indep_bubbles: got %0d/%0d, required 0/0", b1, b2);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 16'd0) begin
            failures++;
            $display("[TB] FAIL indep_r1_early: got %0d, required 0", dbg_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dbg_data !== 16'd5) begin
            failures++;
            $display("[TB] FAIL indep_r1: got %0d, required 5", dbg_data);
        end
        dbg_addr = 3'd2;
        #1;
        checks++;
        if (dbg_data !== 16'd0) begin
            failures++;
            $display("[TB] FAIL indep_r2_early: got %0d, required 0", dbg_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dbg_data !== 16'd7) begin
            failures++;
            $display("[TB] FAIL indep_r2: got %0d, required 7", dbg_data);
        end
        checks++;
        if (busy !== 1'b0 || alu_enable !== 1'b0 || alu_op !== 3'(ALU_ADD) ||
            alu_in1 !== 16'd0 || alu_in2 !== 16'd7) begin
            failures++;
            $display("[TB] FAIL idle_hold: busy=%b en=%b op=%0d in1=%0d in2=%0d, required 0 0 0 0 7",
                     busy, alu_enable, alu_op, alu_in1, alu_in2);
        end
    endtask

    task automatic test_back_to_back();
        int s, b1, b2, exp_b2;
`ifdef ALU_ISSUE_FWD_EN
        exp_b2 = 1;
`else
        exp_b2 = 2;
`endif
        issue(ALU_ADD, 3, 1, 2, 1'b0, 16'd0, s, b1);
        issue(ALU_SUB, 4, 3, 0, 1'b1, 16'd2, s, b2);
        checks++;
        if (b1 != 0 || b2 != exp_b2) begin
            failures++;
            $display("[TB] FAIL dep_bubbles: got %0d/%0d, required 0/%0d", b1, b2, exp_b2);
        end
        drain(4);
        dbg_addr = 3'd3;
        #1;
        checks++;
        if (dbg_data !== 16'd12) begin
            failures++;
            $display("[TB] FAIL dep_r3: got %0d, required 12", dbg_data);
        end
        dbg_addr = 3'd4;
        #1;
        checks++;
        if (dbg_data !== 16'd10) begin
            failures++;
            $display("[TB] FAIL dep_r4: got %0d, required 10", dbg_data);
        end
    endtask

    task automatic test_r0();
        int s, b1, b2;
        issue(ALU_ADD, 0, 0, 0, 1'b1, 16'd9, s, b1);
        issue(ALU_ADD, 5, 0, 0, 1'b1, 16'd1, s, b2);
        checks++;
        if (b1 != 0 || b2 != 0) begin
            failures++;
            $display("[TB] FAIL r0_bubbles: got %0d/%0d, required 0/0", b1, b2);
        end
        drain(4);
        dbg_addr = 3'd0;
        #1;
        checks++;
        if (dbg_data !== 16'd0) begin
            failures++;
            $display("[TB] FAIL r0_value: got %0d, required 0", dbg_data);
        end
        dbg_addr = 3'd5;
        #1;
        checks++;
        if (dbg_data !== 16'd1) begin
            failures++;
            $display("[TB] FAIL r0_r5: got %0d, required 1", dbg_data);
        end
    endtask

    task automatic test_reset_midflight();
        int s, b;
        issue(ALU_ADD, 6, 0, 0, 1'b1, 16'd3, s, b);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || alu_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_state: busy=%b en=%b, required 0 0", busy, alu_enable);
        end
        dbg_addr = 3'd6;
        #1;
        checks++;
        if (dbg_data !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midreset_r6: got %0d, required 0", dbg_data);
        end
        dbg_addr = 3'd5;
        #1;
        checks++;
        if (dbg_data !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midreset_r5: got %0d, required 0", dbg_data);
        end
        clear_model();
        rst_n = 1'b1;
        issue(ALU_ADD, 7, 0, 0, 1'b1, 16'd11, s, b);
        checks++;
        if (b != 0) begin
            failures++;
            $display("[TB] FAIL post_reset_accept: got %0d bubbles, required 0", b);
        end
        drain(4);
        dbg_addr = 3'd7;
        #1;
        checks++;
        if (dbg_data !== 16'd11) begin
            failures++;
            $display("[TB] FAIL post_reset_r7: got %0d, required 11", dbg_data);
        end
    endtask

    task automatic test_imm_mask();
        int s, b1, b2;
        issue(ALU_ADD, 1, 0, 0, 1'b1, 16'd6, s, b1);
        drain(4);
        issue(ALU_ADD, 2, 0, 0, 1'b1, 16'd4, s, b1);
        issue(ALU_MUL, 1, 1, 2, 1'b1, 16'd3, s, b2);
        checks++;
        if (b2 != 0) begin
            failures++;
            $display("[TB] FAIL imm_mask_bubbles: got %0d, required 0", b2);
        end
        drain(4);
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 16'd18) begin
            failures++;
            $display("[TB] FAIL imm_mask_r1: got %0d, required 18", dbg_data);
        end
    endtask

    task automatic test_random();
        int s, b, n, exp_b, rd, rs1, rs2;
        bit imm_en;
        logic [2:0] op;
        logic [WORD_SIZE-1:0] imm;
        for (int k = 0; k < 80; k++) begin
            op     = 3'($urandom_range(0, 7));
            rd     = $urandom_range(0, NREGS - 1);
            rs1    = $urandom_range(0, NREGS - 1);
            rs2    = $urandom_range(0, NREGS - 1);
            imm_en = 1'($urandom_range(0, 1));
            imm    = WORD_SIZE'($urandom_range(0, 40));
            n      = acc_edge.size();
            issue(op, rd, rs1, rs2, imm_en, imm, s, b);
            exp_b  = predict_bubbles(s, n, rs1, rs2, imm_en);
            checks++;
            if (b != exp_b) begin
                failures++;
                $display("[TB] FAIL rand_bubbles #%0d: got %0d, required %0d", k, b, exp_b);
            end
        end
        drain(4);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = RW'(i);
            #1;
            checks++;
            if (dbg_data !== mreg[i]) begin
                failures++;
                $display("[TB] FAIL rand_reg r%0d: got %0d, required %0d", i, dbg_data, mreg[i]);
            end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_independent();
        test_back_to_back();
        test_r0();
        test_reset_midflight();
        test_imm_mask();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
